// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural fetch PC and sequences it every cycle.
//
// The PC advances by 4 in RUN, holds on a hazard stall or when the run
// enable is low, and is redirected to the resolved target of a taken branch
// or jump coming from EX. After a redirect the sequencer spends BUBBLES cycles
// in FLUSH with fetch invalid. A halt request parks it in HALT until reset.
// Saturating counters record taken conditional branches and jumps.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   en                run enable; low in RUN holds PC, fetch invalid
//   stall             hazard stall from decode; holds PC
//   halt              halt request (syscall retire)
//   redir_valid       EX holds a resolved control instruction
//   redir_taken       conditional branch taken
//   redir_is_jump     control instruction is an unconditional jump
//   redir_pc          resolved next PC from the where-to-go unit
//   pc                current fetch PC (registered)
//   pc_4              pc + 4, modulo 2^32
//   fetch_valid       instruction at pc is valid
//   flush             squash IF/ID this cycle (combinational)
//   halted            sequencer is in HALT
//   branch_cnt        taken conditional branches (saturating)
//   jump_cnt          jumps executed (saturating)
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned BUBBLES  = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             stall,
  input  logic             halt,
  input  logic             redir_valid,
  input  logic             redir_taken,
  input  logic             redir_is_jump,
  input  logic [31:0]      redir_pc,
  output logic [31:0]      pc,
  output logic [31:0]      pc_4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] jump_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Counter value loaded on entry to FLUSH; FLUSH exits when it has reached 0,
  // which yields exactly BUBBLES invalid fetch cycles.
  localparam logic [2:0] BUB_RELOAD = (BUBBLES > 0) ? 3'(BUBBLES - 1) : 3'd0;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [2:0]      bub_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] jump_cnt_q;

  logic        redirect;
  logic [31:0] target;
  logic        branch_inc;
  logic        jump_inc;
  logic        unused_pc_lsb;

  assign redirect   = redir_valid & (redir_taken | redir_is_jump) & (state_q != ST_HALT);
  // Instruction addresses are word aligned; misaligned low bits are dropped.
  assign target     = {redir_pc[31:2], 2'b00};
  assign branch_inc = redir_valid & redir_taken & ~redir_is_jump;
  assign jump_inc   = redir_valid & redir_is_jump;
  assign unused_pc_lsb = ^redir_pc[1:0];

  // NOTE: all state below is sequential, so every assignment uses <=; mixing
  // in blocking assignments here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      bub_q        <= 3'd0;
      branch_cnt_q <= '0;
      jump_cnt_q   <= '0;
    end else if (state_q != ST_HALT) begin
      // Statistics also count on the edge that enters HALT.
      if (branch_inc && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (jump_inc && (jump_cnt_q != '1))     jump_cnt_q   <= jump_cnt_q + CNT_W'(1);

      if (halt) begin
        state_q <= ST_HALT;
      end else if (redirect) begin
        // A redirect also wins over FLUSH, restarting the bubble window.
        pc_q <= target;
        if (BUBBLES > 0) begin
          state_q <= ST_FLUSH;
          bub_q   <= BUB_RELOAD;
        end else begin
          state_q <= ST_RUN;
        end
      end else if (state_q == ST_FLUSH) begin
        if (bub_q == 3'd0) state_q <= ST_RUN;
        else               bub_q   <= bub_q - 3'd1;
      end else if (en && !stall) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  assign pc          = pc_q;
  assign pc_4        = pc_q + 32'd4;
  assign fetch_valid = (state_q == ST_RUN) & en;
  // Gated by rst_n so a redirect presented during reset never squashes.
  assign flush       = redirect & rst_n;
  assign halted      = (state_q == ST_HALT);
  assign branch_cnt  = branch_cnt_q;
  assign jump_cnt    = jump_cnt_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural fetch PC and sequences it every cycle: sequential advance, hold on hazard stall, redirect on a resolved control transfer, flush bubbles, halt.
- Consumes the resolved next-PC and branch outcome produced by the combinational where-to-go unit in EX.
- Drives the fetch address, pc+4 and the squash signal for younger pipeline stages.
- Keeps saturating taken-branch and jump statistics counters.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- BUBBLES, 1, number of fetch-invalid cycles after a redirect (0..7; 0 means no FLUSH state).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  run enable; when low in RUN, PC holds and fetch is invalid.
- stall  in  1  hazard stall from decode; holds PC.
- halt  in  1  halt request (syscall retire).
- redir_valid  in  1  EX holds a resolved control instruction this cycle.
- redir_taken  in  1  conditional branch taken (where-to-go branched flag).
- redir_is_jump  in  1  control instruction is an unconditional jump (J26/J32).
- redir_pc  in  32  resolved next PC from where-to-go.
- pc  out  32  current fetch PC (registered).
- pc_4  out  32  pc + 4, combinational, modulo 2^32.
- fetch_valid  out  1  instruction at pc is valid.
- flush  out  1  squash IF/ID this cycle (combinational).
- halted  out  1  sequencer is in HALT.
- branch_cnt  out  CNT_W  taken conditional branches.
- jump_cnt  out  CNT_W  jumps executed.

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_PC, state=RUN, bubble counter=0, halted=0, branch_cnt=0, jump_cnt=0. flush is forced 0 while rst_n is low. Reset mid-FLUSH or mid-HALT returns to RUN immediately.
- Definitions:
  - redirect = redir_valid & (redir_taken | redir_is_jump) & state!=HALT.
  - Target = {redir_pc[31:2],2'b00}; misaligned low bits are discarded.
- States:
  - RUN: fetch_valid = en.
  - FLUSH: fetch_valid=0; PC holds; bubble counter decrements; the state moves to RUN in the cycle the counter reaches 0.
  - HALT: fetch_valid=0, halted=1, PC and counters frozen; exited only by reset.
- Per-edge priority, highest first:
  - halt: to HALT, PC unchanged, even if redirect is also asserted.
  - redirect: pc<=target. If BUBBLES>0, go to FLUSH with counter=BUBBLES-1, else stay in RUN. Overrides stall and en.
  - stall, or en low: hold PC.
  - RUN: pc<=pc+4.
- flush = redirect & rst_n, asserted in the same cycle as the redirect.
- A not-taken conditional branch (redir_valid=1, taken=0, jump=0) causes no PC change beyond the normal advance and no flush.
- A redirect arriving in FLUSH is accepted: it reloads the target and counter, and flush is asserted.
- Counters are updated on every clock edge where state!=HALT, including the edge on which halt is taken:
  - branch_cnt increments on redir_valid & redir_taken & !redir_is_jump.
  - jump_cnt increments on redir_valid & redir_is_jump.
  - Both saturate at all-ones with no wrap.
- PC advance wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Latency: a redirect is visible on pc one cycle after the redir_valid cycle. fetch_valid returns BUBBLES+1 cycles after the redirect cycle.

Test Plan:
- Reset release with en=1, no other input for 4 cycles -> pc goes 0,4,8,C,10; fetch_valid=1; flush=0.
- stall=1 for 2 cycles at pc=8 -> pc holds at 8 for 2 cycles, then 8 then C. Separately, en=0 at pc=8 -> pc holds and fetch_valid=0.
- Taken branch with redir_pc=32'h0000_0103, BUBBLES=1, stall=1 in the same cycle:
  - flush=1 in that cycle.
  - Next cycle pc=32'h100 and fetch_valid=0.
  - Following cycle fetch_valid=1 and pc=32'h100; pc then advances to 104.
  - branch_cnt=1.
- halt and redirect (jump) in the same cycle -> state HALT, pc unchanged, halted=1, jump_cnt=1. Later redirects are ignored. Pulsing rst_n low restores pc=RESET_PC and RUN.
- pc=32'hFFFF_FFFC, run one cycle -> pc=0. Preload branch_cnt to all-ones with CNT_W=4 (15 taken branches), then one more taken branch -> branch_cnt stays 4'hF.
- Not-taken branch (redir_valid=1, taken=0) -> flush=0, pc advances by 4, counters unchanged.
